// File: rtl/macram_mt_param.sv
// Parametrised RAM-based multiply-accumulate bank for one multi-tau correlator
// stage. One accumulator per lag channel lives in a single block RAM. A sample
// strobe sweeps every lag, reading RAM[k] one cycle and writing back
// RAM[k] + A*B_k the next, so each address is touched exactly once per sweep.
// Host reads share the RAM read port and are only accepted while idle.
// The RAM has no reset; software clears it with a clr sweep after power-up or
// after a mid-sweep reset.
module macram_mt_param #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 32,
    parameter int LAG_W = 5,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             clr,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    output logic [LAG_W-1:0] lag,
    output logic             busy,
    output logic             miss,
    input  logic             rd_en,
    input  logic [LAG_W-1:0] rd_addr,
    output logic [ACC_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             ovf,
    output logic [ACC_W-1:0] samples
);

    localparam int DEPTH = 2 ** LAG_W;
    localparam int CNT_W = LAG_W + 1;
    // A MAC sweep needs one extra cycle to retire the write of the last lag.
    localparam logic [CNT_W-1:0] LAST_MAC = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CLR = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        CLR  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             macStart, clrStart, rdAccept, sweepDone, macRead;

    logic             miss_q;
    logic [IN_W-1:0]  aReg_q;
    logic [IN_W-1:0]  b_q;
    logic             wrEn_q;
    logic [LAG_W-1:0] wrAddr_q;

    logic [ACC_W-1:0] mem [DEPTH];
    logic [ACC_W-1:0] ramRdata_q;
    logic [LAG_W-1:0] ramRdAddr;
    logic             memWe;
    logic [LAG_W-1:0] memWaddr;
    logic [ACC_W-1:0] memWdata;

    logic [2*IN_W-1:0] prod;
    logic [ACC_W:0]    prodExt;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  macResult;

    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] samples_q, samples_d;

    logic             rdPend_q;
    logic             rdValid_q;
    logic [ACC_W-1:0] rdData_q;

    // Next-state logic: sin beats clr beats rd_en in IDLE; the counter walks the lags.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        macStart = 1'b0;
        clrStart = 1'b0;
        rdAccept = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sin) begin
                    state_d  = MAC;
                    macStart = 1'b1;
                end else if (clr) begin
                    state_d  = CLR;
                    clrStart = 1'b1;
                end else if (rd_en) begin
                    rdAccept = 1'b1;
                end
            end
            MAC: begin
                if (cnt_q == LAST_MAC) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CLR: begin
                if (cnt_q == LAST_CLR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign sweepDone = (state_q == MAC) && (cnt_q == LAST_MAC);
    assign macRead   = (state_q == MAC) && (cnt_q != LAST_MAC);
    assign busy      = (state_q != IDLE);
    assign lag       = (state_q == MAC) ? cnt_q[LAG_W-1:0] : '0;
    assign miss      = miss_q;

    // FSM state register and the dropped-sample pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            miss_q  <= sin && (state_q != IDLE);
        end
    end

    // MAC pipeline: latch A at acceptance, and B plus the lag for next cycle's write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            aReg_q   <= '0;
            b_q      <= '0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
        end else begin
            if (macStart) begin
                aReg_q <= A;
            end
            b_q      <= B;
            wrEn_q   <= macRead;
            wrAddr_q <= cnt_q[LAG_W-1:0];
        end
    end

    assign prod = {{IN_W{1'b0}}, aReg_q} * {{IN_W{1'b0}}, b_q};

    // Accumulate with one guard bit so an overflow can be flagged and optionally clamped.
    always_comb begin
        prodExt                = '0;
        prodExt[2*IN_W-1:0]    = prod;
        sum                    = {1'b0, ramRdata_q} + prodExt;
        macResult              = sum[ACC_W-1:0];
        if (SAT && sum[ACC_W]) begin
            macResult = '1;
        end
    end

    // The RAM read port is owned by the sweep during MAC and by the host otherwise.
    assign ramRdAddr = (state_q == MAC) ? cnt_q[LAG_W-1:0] : rd_addr;
    assign memWe     = wrEn_q || (state_q == CLR);
    assign memWaddr  = (state_q == CLR) ? cnt_q[LAG_W-1:0] : wrAddr_q;
    assign memWdata  = (state_q == CLR) ? '0 : macResult;

    // Block RAM: one synchronous write port, one registered read port, no reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memWaddr] <= memWdata;
        end
        ramRdata_q <= mem[ramRdAddr];
    end

    // Sticky overflow and completed-sample counter; both zeroed when a clear starts.
    always_comb begin
        ovf_d     = ovf_q;
        samples_d = samples_q;
        if (clrStart) begin
            ovf_d     = 1'b0;
            samples_d = '0;
        end else begin
            if (wrEn_q && sum[ACC_W]) begin
                ovf_d = 1'b1;
            end
            if (sweepDone && !(SAT && (&samples_q))) begin
                samples_d = samples_q + ACC_W'(1);
            end
        end
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            samples_q <= '0;
        end else begin
            ovf_q     <= ovf_d;
            samples_q <= samples_d;
        end
    end

    assign ovf     = ovf_q;
    assign samples = samples_q;

    // Host read pipeline: RAM access, then output register; rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPend_q  <= 1'b0;
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
        end else begin
            rdPend_q  <= rdAccept;
            rdValid_q <= rdPend_q;
            if (rdPend_q) begin
                rdData_q <= ramRdata_q;
            end
        end
    end

    assign rd_valid = rdValid_q;
    assign rd_data  = rdData_q;

endmodule

// File: tb/tb_macram_mt_param.sv
// Bench for macram_mt_param: four instances with different parameter sets share
// rst/clr/A/rd_en/rd_addr; each has its own sample strobe and a B operand derived
// from its own lag output (either the lag index itself or a constant).
module tb_macram_mt_param;

    logic clk;
    logic rst;
    logic clr;
    logic rdEn;
    logic [5:0]  rdAddr;
    logic [11:0] aIn;
    logic        bIsLag;
    logic [11:0] bConst;
    logic [3:0]  sinV;

    // d0: 8/32/5 SAT, d1: 8/16/3 wrap, d2: 8/16/3 SAT, d3: 12/40/6 SAT
    logic [7:0]  b0, b1, b2;
    logic [11:0] b3;
    logic [4:0]  lag0;
    logic [2:0]  lag1, lag2;
    logic [5:0]  lag3;
    logic [31:0] rdData0, samples0;
    logic [15:0] rdData1, samples1, rdData2, samples2;
    logic [39:0] rdData3, samples3;
    logic [3:0]  busyV, missV, rdValidV, ovfV;

    logic [39:0] rdDataV [4];
    logic [39:0] samplesV [4];
    logic [5:0]  lagV [4];
    int          depthOf [4];

    int total;
    int bad;
    int cyc;

    int sweepLen;
    bit sweepLagOk;
    bit sweepRdSeen;
    int sweepMissCnt;
    int sweepMissAt;
    int sweepStart;
    int clrLen [4];

    assign b0 = bIsLag ? 8'(lag0) : bConst[7:0];
    assign b1 = bIsLag ? 8'(lag1) : bConst[7:0];
    assign b2 = bIsLag ? 8'(lag2) : bConst[7:0];
    assign b3 = bIsLag ? 12'(lag3) : bConst;

    assign rdDataV[0]  = 40'(rdData0);
    assign rdDataV[1]  = 40'(rdData1);
    assign rdDataV[2]  = 40'(rdData2);
    assign rdDataV[3]  = rdData3;
    assign samplesV[0] = 40'(samples0);
    assign samplesV[1] = 40'(samples1);
    assign samplesV[2] = 40'(samples2);
    assign samplesV[3] = samples3;
    assign lagV[0]     = 6'(lag0);
    assign lagV[1]     = 6'(lag1);
    assign lagV[2]     = 6'(lag2);
    assign lagV[3]     = lag3;

    macram_mt_param #(.IN_W(8), .ACC_W(32), .LAG_W(5), .SAT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .sin(sinV[0]), .clr(clr), .A(aIn[7:0]), .B(b0),
        .lag(lag0), .busy(busyV[0]), .miss(missV[0]), .rd_en(rdEn),
        .rd_addr(rdAddr[4:0]), .rd_data(rdData0), .rd_valid(rdValidV[0]),
        .ovf(ovfV[0]), .samples(samples0)
    );
    macram_mt_param #(.IN_W(8), .ACC_W(16), .LAG_W(3), .SAT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .sin(sinV[1]), .clr(clr), .A(aIn[7:0]), .B(b1),
        .lag(lag1), .busy(busyV[1]), .miss(missV[1]), .rd_en(rdEn),
        .rd_addr(rdAddr[2:0]), .rd_data(rdData1), .rd_valid(rdValidV[1]),
        .ovf(ovfV[1]), .samples(samples1)
    );
    macram_mt_param #(.IN_W(8), .ACC_W(16), .LAG_W(3), .SAT(1'b1)) dut2 (
        .clk(clk), .rst(rst), .sin(sinV[2]), .clr(clr), .A(aIn[7:0]), .B(b2),
        .lag(lag2), .busy(busyV[2]), .miss(missV[2]), .rd_en(rdEn),
        .rd_addr(rdAddr[2:0]), .rd_data(rdData2), .rd_valid(rdValidV[2]),
        .ovf(ovfV[2]), .samples(samples2)
    );
    macram_mt_param #(.IN_W(12), .ACC_W(40), .LAG_W(6), .SAT(1'b1)) dut3 (
        .clk(clk), .rst(rst), .sin(sinV[3]), .clr(clr), .A(aIn), .B(b3),
        .lag(lag3), .busy(busyV[3]), .miss(missV[3]), .rd_en(rdEn),
        .rd_addr(rdAddr), .rd_data(rdData3), .rd_valid(rdValidV[3]),
        .ovf(ovfV[3]), .samples(samples3)
    );

    // Free-running clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Hard stop in case something wedges despite the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Clear sweep on every instance, recording how long each one stays busy.
    task automatic runClr();
        int i;
        for (int s = 0; s < 4; s++) clrLen[s] = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        i = 0;
        while ((busyV != 4'b0) && (i < 300)) begin
            for (int s = 0; s < 4; s++) if (busyV[s]) clrLen[s]++;
            i++;
            tick();
        end
    endtask

    // MAC sweep on one instance; optional extra clr/rd_en with the strobe and one
    // injected sin (kind 0) or rd_en (kind 1) at a given busy cycle index.
    task automatic applyStimulus(input int sel, input int a, input bit bLag, input int bc,
                                 input bit withClr, input bit withRd,
                                 input int injAt, input int injKind);
        aIn          = 12'(a);
        bIsLag       = bLag;
        bConst       = 12'(bc);
        sinV[sel]    = 1'b1;
        clr          = withClr;
        rdEn         = withRd;
        sweepStart   = cyc;
        tick();
        sinV         = '0;
        clr          = 1'b0;
        rdEn         = 1'b0;
        sweepLen     = 0;
        sweepLagOk   = 1'b1;
        sweepRdSeen  = 1'b0;
        sweepMissCnt = 0;
        sweepMissAt  = -1;
        while (busyV[sel] && (sweepLen < 300)) begin
            if ((sweepLen < depthOf[sel]) && (int'(lagV[sel]) != sweepLen)) sweepLagOk = 1'b0;
            if (rdValidV[sel]) sweepRdSeen = 1'b1;
            if (missV[sel]) begin
                sweepMissCnt++;
                if (sweepMissAt < 0) sweepMissAt = sweepLen;
            end
            sinV = '0;
            rdEn = 1'b0;
            if (sweepLen == injAt) begin
                if (injKind == 0) begin
                    sinV[sel] = 1'b1;
                    aIn       = 12'd100;
                end else begin
                    rdEn = 1'b1;
                end
            end
            sweepLen++;
            tick();
        end
        sinV = '0;
        rdEn = 1'b0;
        if (missV[sel]) sweepMissCnt++;
        if (rdValidV[sel]) sweepRdSeen = 1'b1;
    endtask

    // Single host read; reports the word and whether it arrived exactly two cycles later.
    task automatic readLag(input int sel, input int addr, output longint data, output bit latOk);
        bit v1, v2;
        rdAddr = 6'(addr);
        rdEn   = 1'b1;
        tick();
        rdEn = 1'b0;
        v1   = rdValidV[sel];
        tick();
        v2    = rdValidV[sel];
        data  = longint'(rdDataV[sel]);
        latOk = !v1 && v2;
    endtask

    typedef struct {
        int     sel;
        int     nSweeps;
        int     a;
        bit     bLag;
        int     b;
        int     probe;
        longint expData;
        bit     expOvf;
        int     expSamples;
    } vec_t;

    initial begin
        vec_t   vecs [8];
        longint rd;
        bit     latOk;
        bit     rdSeen;
        int     prevStart;
        int     i;

        depthOf[0] = 32; depthOf[1] = 8; depthOf[2] = 8; depthOf[3] = 64;
        vecs[0] = '{0,  1,    3, 1'b1,    0, 31,       93, 1'b0,  1};
        vecs[1] = '{0, 10,  255, 1'b0,  255, 17,   650250, 1'b0, 10};
        vecs[2] = '{2,  2,  255, 1'b0,  255,  5,    65535, 1'b1,  2};
        vecs[3] = '{1,  2,  255, 1'b0,  255,  6,    64514, 1'b1,  2};
        vecs[4] = '{1,  1,  255, 1'b0,  255,  0,    65025, 1'b0,  1};
        vecs[5] = '{3,  1, 4095, 1'b0, 4095, 63, 16769025, 1'b0,  1};
        vecs[6] = '{3,  1,    5, 1'b1,    0, 63,      315, 1'b0,  1};
        vecs[7] = '{2,  1,    7, 1'b1,    0,  7,       49, 1'b0,  1};

        total = 0; bad = 0; cyc = 0;
        rst = 1'b1; clr = 1'b0; rdEn = 1'b0; rdAddr = '0;
        aIn = '0; bIsLag = 1'b0; bConst = '0; sinV = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset values.
        checkOutput("rst_busy",    busyV[0], 0);
        checkOutput("rst_miss",    missV[0], 0);
        checkOutput("rst_rdvalid", rdValidV[0], 0);
        checkOutput("rst_ovf",     ovfV[0], 0);
        checkOutput("rst_lag",     lagV[0], 0);
        checkOutput("rst_samples", samplesV[0], 0);
        checkOutput("rst_rddata",  rdDataV[0], 0);

        // Clear-sweep busy lengths equal DEPTH on every instance.
        runClr();
        for (int s = 0; s < 4; s++) checkOutput($sformatf("clr_len%0d", s), clrLen[s], depthOf[s]);

        // Basic MAC then back-to-back reads of every lag.
        applyStimulus(0, 3, 1'b1, 0, 1'b0, 1'b0, -1, 0);
        checkOutput("basic_len", sweepLen, 33);
        checkOutput("basic_lagorder", sweepLagOk, 1);
        for (int k = 0; k <= 32; k++) begin
            if (k < 32) begin
                rdEn   = 1'b1;
                rdAddr = 6'(k);
            end else begin
                rdEn = 1'b0;
            end
            tick();
            if (k >= 1) begin
                checkOutput($sformatf("b2b_valid%0d", k - 1), rdValidV[0], 1);
                checkOutput($sformatf("b2b_data%0d", k - 1), rdDataV[0], 3 * (k - 1));
            end
        end
        tick();
        checkOutput("b2b_valid_end", rdValidV[0], 0);
        checkOutput("basic_samples", samplesV[0], 1);
        checkOutput("basic_ovf", ovfV[0], 0);

        // Table-driven sweeps across the parameter sets.
        for (int v = 0; v < 8; v++) begin
            runClr();
            prevStart = 0;
            for (int n = 0; n < vecs[v].nSweeps; n++) begin
                prevStart = sweepStart;
                applyStimulus(vecs[v].sel, vecs[v].a, vecs[v].bLag, vecs[v].b, 1'b0, 1'b0, -1, 0);
                if (n > 0)
                    checkOutput($sformatf("v%0d_spacing", v), sweepStart - prevStart,
                                depthOf[vecs[v].sel] + 2);
            end
            checkOutput($sformatf("v%0d_len", v), sweepLen, depthOf[vecs[v].sel] + 1);
            checkOutput($sformatf("v%0d_lagorder", v), sweepLagOk, 1);
            readLag(vecs[v].sel, vecs[v].probe, rd, latOk);
            checkOutput($sformatf("v%0d_data", v), rd, vecs[v].expData);
            checkOutput($sformatf("v%0d_latency", v), latOk, 1);
            checkOutput($sformatf("v%0d_ovf", v), ovfV[vecs[v].sel], vecs[v].expOvf);
            checkOutput($sformatf("v%0d_samples", v), samplesV[vecs[v].sel], vecs[v].expSamples);
        end

        // Saturation followed by clear zeroes data, ovf and samples.
        runClr();
        applyStimulus(2, 255, 1'b0, 255, 1'b0, 1'b0, -1, 0);
        applyStimulus(2, 255, 1'b0, 255, 1'b0, 1'b0, -1, 0);
        checkOutput("satclr_ovf_before", ovfV[2], 1);
        runClr();
        checkOutput("satclr_ovf", ovfV[2], 0);
        checkOutput("satclr_samples", samplesV[2], 0);
        readLag(2, 3, rd, latOk);
        checkOutput("satclr_data", rd, 0);

        // sin at cycle T+5 of a sweep is dropped with a miss pulse one cycle later.
        runClr();
        applyStimulus(0, 3, 1'b1, 0, 1'b0, 1'b0, 4, 0);
        checkOutput("coll_miss_cnt", sweepMissCnt, 1);
        checkOutput("coll_miss_at", sweepMissAt, 5);
        checkOutput("coll_len", sweepLen, 33);
        readLag(0, 10, rd, latOk);
        checkOutput("coll_data", rd, 30);
        checkOutput("coll_samples", samplesV[0], 1);

        // rd_en during busy produces no rd_valid.
        applyStimulus(0, 3, 1'b1, 0, 1'b0, 1'b0, 2, 1);
        checkOutput("busyrd_novalid", sweepRdSeen, 0);
        tick();
        checkOutput("busyrd_novalid_after", rdValidV[0], 0);

        // sin, clr and rd_en together: MAC sweep only, no read.
        applyStimulus(0, 1, 1'b0, 1, 1'b1, 1'b1, -1, 0);
        checkOutput("triple_len", sweepLen, 33);
        checkOutput("triple_novalid", sweepRdSeen, 0);
        checkOutput("triple_samples", samplesV[0], 3);
        readLag(0, 10, rd, latOk);
        checkOutput("triple_data", rd, 61);

        // Reset in the middle of a sweep at lag 7.
        aIn = 12'd1; bIsLag = 1'b0; bConst = 12'd2;
        sinV[0] = 1'b1;
        tick();
        sinV = '0;
        i = 0;
        while ((int'(lagV[0]) != 7) && (i < 50)) begin
            i++;
            tick();
        end
        checkOutput("mid_reached_lag7", lagV[0], 7);
        rst = 1'b1;
        tick();
        checkOutput("mid_busy", busyV[0], 0);
        checkOutput("mid_lag", lagV[0], 0);
        checkOutput("mid_samples", samplesV[0], 0);
        checkOutput("mid_rddata", rdDataV[0], 0);
        checkOutput("mid_rdvalid", rdValidV[0], 0);
        checkOutput("mid_miss", missV[0], 0);
        checkOutput("mid_ovf", ovfV[0], 0);
        rst = 1'b0;
        tick();
        runClr();
        applyStimulus(0, 1, 1'b0, 2, 1'b0, 1'b0, -1, 0);
        readLag(0, 0, rd, latOk);
        checkOutput("mid_data0", rd, 2);
        readLag(0, 31, rd, latOk);
        checkOutput("mid_data31", rd, 2);
        checkOutput("mid_samples_after", samplesV[0], 1);

        rdSeen = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
